// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sweep_ctrl
//  Purpose  : Sequencer for an external up/down counter. Clears the counter,
//             seeks up to a programmed low limit, then performs N ping-pong
//             sweeps lo->hi->lo and reports completion. The counter value is
//             read back on count_in_i so that enable/direction can be cut in
//             the same cycle a limit is reached (no overshoot).
//
//  Ports    :
//    clk           in   system clock, rising edge
//    rst           in   asynchronous active-high reset
//    start_i       in   1-cycle command pulse, sampled only when idle
//    stop_i        in   abort request, overrides every other input when busy
//    pause_i       in   level; freezes counting and sequencing while high
//    lo_lim_i      in   low sweep limit  (latched on accepted start)
//    hi_lim_i      in   high sweep limit (latched on accepted start)
//    n_sweeps_i    in   number of full sweeps (latched on accepted start)
//    count_in_i    in   counter value fed back from the counter output
//    cnt_en_o      out  counter enable
//    cnt_dir_o     out  counter direction (1 = up)
//    cnt_rst_o     out  counter synchronous clear request
//    busy_o        out  high in every state except idle
//    done_o        out  1-cycle pulse, all sweeps complete
//    aborted_o     out  1-cycle pulse, stop accepted while busy
//    err_o         out  1-cycle pulse, start rejected (bad limits / n = 0)
//    sweep_cnt_o   out  sweeps completed in the current run
//
//  Revision : 1.0  initial release
// ============================================================================
module counter_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               pause_i,
    input  logic [WIDTH-1:0]   lo_lim_i,
    input  logic [WIDTH-1:0]   hi_lim_i,
    input  logic [SWEEP_W-1:0] n_sweeps_i,
    input  logic [WIDTH-1:0]   count_in_i,
    output logic               cnt_en_o,
    output logic               cnt_dir_o,
    output logic               cnt_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic               err_o,
    output logic [SWEEP_W-1:0] sweep_cnt_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEEK  = 3'd2,
        ST_UP    = 3'd3,
        ST_DOWN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   lo_q,        lo_d;
    logic [WIDTH-1:0]   hi_q,        hi_d;
    logic [SWEEP_W-1:0] n_q,         n_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic               done_q,      done_d;
    logic               aborted_q,   aborted_d;
    logic               err_q,       err_d;

    // Combinational counter controls
    logic               w_cnt_en;
    logic               w_cnt_dir;
    logic               w_cnt_rst;

    // ------------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------------
    logic               w_start_ok;
    logic               w_at_lo;
    logic               w_at_hi;
    logic [SWEEP_W-1:0] w_sweep_inc;
    logic               w_stop_busy;

    // A run is only accepted if there is a real span to sweep and at least
    // one sweep to do; unsigned full-width compare.
    assign w_start_ok  = (lo_lim_i < hi_lim_i) && (n_sweeps_i != '0);

    // Limit detection always uses the latched limits so that the host may
    // change lo_lim_i/hi_lim_i while a run is in progress.
    assign w_at_lo     = (count_in_i == lo_q);
    assign w_at_hi     = (count_in_i == hi_q);

    assign w_sweep_inc = sweep_cnt_q + SWEEP_W'(1);

    assign w_stop_busy = stop_i && (state_q != ST_IDLE);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            n_q         <= '0;
            sweep_cnt_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
            sweep_cnt_q <= sweep_cnt_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        n_d         = n_q;
        sweep_cnt_d = sweep_cnt_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        err_d       = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_dir   = 1'b1;
        w_cnt_rst   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_start_ok) begin
                        lo_d        = lo_lim_i;
                        hi_d        = hi_lim_i;
                        n_d         = n_sweeps_i;
                        sweep_cnt_d = '0;
                        state_d     = ST_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                w_cnt_rst = 1'b1;
                state_d   = ST_SEEK;
            end

            // In SEEK/UP/DOWN the enable drops in the very cycle the limit is
            // seen, so every turning point dwells exactly one cycle. While
            // paused the state is frozen as well, so the dwell is simply
            // extended by the pause length.
            ST_SEEK: begin
                w_cnt_dir = 1'b1;
                w_cnt_en  = !w_at_lo && !pause_i;
                if (!pause_i && w_at_lo) begin
                    state_d = ST_UP;
                end
            end

            ST_UP: begin
                w_cnt_dir = 1'b1;
                w_cnt_en  = !w_at_hi && !pause_i;
                if (!pause_i && w_at_hi) begin
                    state_d = ST_DOWN;
                end
            end

            ST_DOWN: begin
                w_cnt_dir = 1'b0;
                w_cnt_en  = !w_at_lo && !pause_i;
                if (!pause_i && w_at_lo) begin
                    // Returning to lo closes one full sweep.
                    sweep_cnt_d = w_sweep_inc;
                    if (w_sweep_inc == n_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_UP;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything once a run is active: the counter is
        // frozen in this cycle and the sweep count keeps its value.
        if (w_stop_busy) begin
            state_d     = ST_IDLE;
            sweep_cnt_d = sweep_cnt_q;
            w_cnt_en    = 1'b0;
            w_cnt_rst   = 1'b0;
            done_d      = 1'b0;
            aborted_d   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cnt_en_o    = w_cnt_en;
    assign cnt_dir_o   = w_cnt_dir;
    assign cnt_rst_o   = w_cnt_rst;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign err_o       = err_q;
    assign sweep_cnt_o = sweep_cnt_q;

endmodule
`default_nettype wire

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that drives the team's 8-bit up/down counter through its enable, dir and rst inputs.
- Clears the counter, seeks up to a programmed low limit, then runs N ping-pong sweeps lo->hi->lo and signals completion.
- Sits between a host/command interface and one counter instance; it reads the counter's counter_out back as count_in.

Parameters:
WIDTH, 8, counter/limit width
SWEEP_W, 8, width of sweep-count register and n_sweeps

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  1-cycle command pulse; sampled only in IDLE
stop  in  1  abort; priority over every other input
pause  in  1  level; freezes counting while high
lo_lim  in  WIDTH  low sweep limit, latched on accepted start
hi_lim  in  WIDTH  high sweep limit, latched on accepted start
n_sweeps  in  SWEEP_W  full sweeps to run, latched on accepted start
count_in  in  WIDTH  counter value fed back from counter_out
cnt_en  out  1  to counter enable
cnt_dir  out  1  to counter dir (1 = up)
cnt_rst  out  1  to counter rst (synchronous clear request)
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse, all sweeps complete
aborted  out  1  1-cycle pulse, stop accepted while busy
err  out  1  1-cycle pulse, start rejected
sweep_cnt  out  SWEEP_W  sweeps completed in the current run

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; latched limits and sweep_cnt = 0.
  - done, aborted, err = 0; cnt_en=0, cnt_dir=1, cnt_rst=0, busy=0.
- States: IDLE, CLEAR, SEEK, UP, DOWN, DONE. done, aborted and err are registered.
- cnt_en and cnt_dir are combinational from state, pause and count_in, so the counter never overshoots a limit.
- IDLE: cnt_en=0.
  - On start=1 with lo_lim<hi_lim and n_sweeps!=0: latch lo_lim, hi_lim and n_sweeps; clear sweep_cnt; go to CLEAR.
  - On start=1 with invalid limits or n_sweeps=0: err=1 next cycle, stay in IDLE.
- CLEAR (exactly 1 cycle): cnt_rst=1, cnt_en=0; go to SEEK.
- SEEK: cnt_dir=1, cnt_en=(count_in!=lo)&~pause. When count_in==lo, go to UP.
- UP: cnt_dir=1, cnt_en=(count_in!=hi)&~pause. When count_in==hi, go to DOWN.
- DOWN: cnt_dir=0, cnt_en=(count_in!=lo)&~pause.
  - When count_in==lo: sweep_cnt+=1.
  - If the new value equals n_sweeps, go to DONE; otherwise go to UP.
- Each limit therefore dwells exactly one cycle (en=0) at every turning point.
- DONE: cnt_en=0, done=1 in the following cycle; go to IDLE. sweep_cnt holds its final value until the next accepted start.
- stop=1 in any non-IDLE state: go to IDLE next edge, cnt_en=0 that cycle, aborted=1 next cycle, sweep_cnt holds. stop in IDLE has no effect.
- pause does not change state; stop wins over pause.
- start while busy is ignored; there is no err for it.
- Latched limits are used throughout a run; live lo_lim/hi_lim changes are ignored.
- lo=0: SEEK lasts 1 cycle. hi=2^WIDTH-1: legal, and the counter never wraps.
- Comparisons are unsigned, full WIDTH.
- Reset mid-run: immediate return to reset values.

Test Plan:
- Reset: rst=1 for 1 cycle mid-sweep -> state IDLE, cnt_en=0, busy=0, sweep_cnt=0, all pulses 0.
- Basic run: lo=2, hi=4, n=1, start -> counter trace 0,0(clear),1,2,2,3,4,4,3,2,2(DONE). done=1 for one cycle, sweep_cnt=1, busy falls with done.
- Multi-sweep: lo=0, hi=3, n=3 -> count oscillates 0..3 three times. sweep_cnt steps 1,2,3 at each return to 0. Exactly one done pulse.
- Reject: start with lo=5, hi=5 -> err=1 for one cycle, busy stays 0. Repeat with n=0 -> same result.
- Pause/stop:
  - pause=1 for 3 cycles during UP at count=3 -> count holds 3 for 3 cycles, then resumes to 4.
  - stop during DOWN -> aborted pulse, cnt_en=0, counter frozen, IDLE.
- Boundary: lo=254, hi=255, n=2 -> count never exceeds 255 or wraps to 0 after CLEAR/SEEK. done after 2 sweeps.
